div_mant_seq: RTL and testbench

Sequential restoring divider for the 24-bit significands (hidden bit included) of the FP divide path. It is the divide-direction counterpart of the mantissa multiplier.
- Produces quotient = floor(Mantissa_A·2^25 / Mantissa_B), one bit per clock, plus a sticky bit for the rounding stage.
- Sits between exponent-subtract/sign logic and the shared normalize/round stage.

---
 rtl/fp_div_pkg.sv | 14 +
 rtl/div_step.sv | 24 ++
 rtl/div_mant_seq.sv | 116 +++++++++++
 tb/tb_div_mant_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared constants and state encoding for the significand divider
package fp_div_pkg;

  localparam int MANT_W = 24;
  localparam int Q_W    = MANT_W + 2;
  localparam int CNT_W  = $clog2(Q_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: compare, conditional subtract, shift
module div_step
  import fp_div_pkg::*;
#(
  parameter int MANT_W = fp_div_pkg::MANT_W
) (
  input  logic [MANT_W:0]   r,
  input  logic [MANT_W-1:0] b,
  output logic              q_bit,
  output logic [MANT_W:0]   r_next
);

  logic [MANT_W:0]   b_ext;
  logic [MANT_W-1:0] diff;

  // With R < 2B the difference always fits in MANT_W bits, so the shift never loses a one.
  always_comb begin
    b_ext  = {1'b0, b};
    q_bit  = (r >= b_ext);
    diff   = q_bit ? MANT_W'(r - b_ext) : r[MANT_W-1:0];
    r_next = {diff, 1'b0};
  end

endmodule

// File: rtl/div_mant_seq.sv
// rtl/div_mant_seq.sv - radix-2 restoring divider for FP significands, one quotient bit per clock
module div_mant_seq #(
  parameter int MANT_W = fp_div_pkg::MANT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Start,
  input  logic [MANT_W-1:0] Mantissa_A,
  input  logic [MANT_W-1:0] Mantissa_B,
  output logic              Busy,
  output logic              Done,
  output logic [MANT_W+1:0] Cociente,
  output logic              Sticky,
  output logic              Div_Zero
);

  import fp_div_pkg::*;

  localparam int Q_W   = MANT_W + 2;
  localparam int CNT_W = $clog2(Q_W);

  state_t            state_q, state_d;
  logic [MANT_W:0]   rem_q, rem_d;
  logic [MANT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [Q_W-1:0]    quo_q, quo_d;
  logic              sticky_q, sticky_d;
  logic              dz_q, dz_d;
  logic              done_q, done_d;

  logic              step_q_bit;
  logic [MANT_W:0]   step_r_next;

  div_step #(.MANT_W(MANT_W)) u_step (
    .r      (rem_q),
    .b      (div_q),
    .q_bit  (step_q_bit),
    .r_next (step_r_next)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    sticky_d = sticky_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (Mantissa_B != '0) begin
            div_d    = Mantissa_B;
            rem_d    = {1'b0, Mantissa_A};
            cnt_d    = CNT_W'(Q_W - 1);
            quo_d    = '0;
            sticky_d = 1'b0;
            dz_d     = 1'b0;
            state_d  = ST_RUN;
          end else begin
            quo_d    = '1;
            sticky_d = 1'b0;
            dz_d     = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        quo_d[cnt_q] = step_q_bit;
        rem_d        = step_r_next;
        if (cnt_q == '0) begin
          // A left shift by one preserves zero/non-zero, so the shifted value suffices.
          sticky_d = (step_r_next != '0);
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      quo_q    <= '0;
      sticky_q <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      sticky_q <= sticky_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign Busy     = (state_q == ST_RUN);
  assign Done     = done_q;
  assign Cociente = quo_q;
  assign Sticky   = sticky_q;
  assign Div_Zero = dz_q;

endmodule

// File: tb/tb_div_mant_seq.sv
// tb/tb_div_mant_seq.sv - directed and random checks of div_mant_seq against an arithmetic model
module tb_div_mant_seq;

  localparam int MANT_W = 24;
  localparam int Q_W    = MANT_W + 2;
  localparam int LAT    = Q_W + 2;

  logic              clk;
  logic              rst_n;
  logic              Start;
  logic [MANT_W-1:0] Mantissa_A;
  logic [MANT_W-1:0] Mantissa_B;
  logic              Busy;
  logic              Done;
  logic [Q_W-1:0]    Cociente;
  logic              Sticky;
  logic              Div_Zero;

  int checks   = 0;
  int failures = 0;

  div_mant_seq #(.MANT_W(MANT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Start      (Start),
    .Mantissa_A (Mantissa_A),
    .Mantissa_B (Mantissa_B),
    .Busy       (Busy),
    .Done       (Done),
    .Cociente   (Cociente),
    .Sticky     (Sticky),
    .Div_Zero   (Div_Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Quotient = floor(A * 2^25 / B); sticky when that division leaves a remainder.
  task automatic ref_div(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                         output logic [Q_W-1:0] q, output logic s, output logic z);
    logic [63:0] num;
    if (b == '0) begin
      q = '1;
      s = 1'b0;
      z = 1'b1;
    end else begin
      num = {15'd0, a, 25'd0};
      q   = Q_W'(num / {40'd0, b});
      s   = ((num % {40'd0, b}) != 64'd0);
      z   = 1'b0;
    end
  endtask

  task automatic do_div(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b);
    logic [Q_W-1:0] eq;
    logic           es, ez;
    int             cyc;
    ref_div(a, b, eq, es, ez);
    @(negedge clk);
    Start = 1'b1; Mantissa_A = a; Mantissa_B = b;
    @(negedge clk);
    Start = 1'b0;
    cyc   = 1;
    if (b != '0) begin
      check("busy_run", Busy, 1);
      check("quo_cleared", Cociente, 0);
    end
    while (Done !== 1'b1 && cyc < 3 * LAT) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, (b == '0) ? 2 : LAT);
    check("quotient", Cociente, eq);
    check("sticky", Sticky, es);
    check("div_zero", Div_Zero, ez);
    @(negedge clk);
    check("done_single", Done, 0);
    check("quo_hold", Cociente, eq);
  endtask

  initial begin
    logic [Q_W-1:0] eq, q_cap;
    logic           es, ez, s_cap;
    logic [31:0]    ra, rb;
    int             busy_cnt, done_cnt;

    rst_n = 1'b0; Start = 1'b0; Mantissa_A = '0; Mantissa_B = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_quo", Cociente, 0);
    check("rst_sticky", Sticky, 0);
    check("rst_dz", Div_Zero, 0);
    rst_n = 1'b1;

    do_div(24'h800000, 24'h800000);
    check("one_by_one_q", Cociente, 26'h2000000);
    check("one_by_one_s", Sticky, 0);
    do_div(24'hC00000, 24'h800000);
    check("c_by_8_q", Cociente, 26'h3000000);
    do_div(24'hFFFFFF, 24'h800000);
    check("max_by_8_q", Cociente, 26'h3FFFFFC);
    check("max_by_8_s", Sticky, 0);
    do_div(24'h800000, 24'hC00000);
    check("8_by_c_q", Cociente, 26'h1555555);
    check("8_by_c_s", Sticky, 1);

    do_div(24'($urandom), 24'h000000);
    check("dz_q", Cociente, 26'h3FFFFFF);
    check("dz_flag", Div_Zero, 1);
    do_div(24'h900000, 24'hA00000);
    check("dz_cleared", Div_Zero, 0);

    // Second Start during RUN must be ignored.
    ref_div(24'hABCDEF, 24'h912345, eq, es, ez);
    @(negedge clk);
    Start = 1'b1; Mantissa_A = 24'hABCDEF; Mantissa_B = 24'h912345;
    @(negedge clk);
    busy_cnt = 0; done_cnt = 0; q_cap = '0; s_cap = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (Busy === 1'b1) busy_cnt++;
      if (Done === 1'b1) begin
        done_cnt++;
        q_cap = Cociente;
        s_cap = Sticky;
      end
      if (c == 5) begin
        Start = 1'b1; Mantissa_A = 24'hFFFFFF; Mantissa_B = 24'h800001;
      end else begin
        Start = 1'b0;
      end
      @(negedge clk);
    end
    check("restart_busy_cycles", busy_cnt, Q_W);
    check("restart_done_count", done_cnt, 1);
    check("restart_q", q_cap, eq);
    check("restart_s", s_cap, es);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    Start = 1'b1; Mantissa_A = 24'hF00000; Mantissa_B = 24'h812345;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_quo", Cociente, 0);
    check("abort_sticky", Sticky, 0);
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (Done === 1'b1) done_cnt++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk);
      if (Done === 1'b1) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    do_div(24'hF00000, 24'h812345);

    for (int i = 0; i < 16; i++) begin
      do_div({1'b1, 23'($urandom)}, {1'b1, 23'($urandom)});
    end
    for (int i = 0; i < 6; i++) begin
      rb = $urandom_range(32'h00FFFFFF, 32'h1);
      ra = $urandom % (2 * rb);
      if (ra > 32'h00FFFFFF) ra = 32'h00FFFFFF;
      do_div(24'(ra), 24'(rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
